fetch_stage: RTL

Instruction fetch stage that sits directly upstream of `instrMem`. It owns the program counter and drives the memory byte address. It captures the 32-bit big-endian word returned combinationally into an IF/ID output register, which the decode stage drains through a valid/ready handshake. It also handles branch/jump redirects, stalls, and out-of-range or misaligned PC faults.

---
 rtl/fetch_stage.sv | 93 +++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives instrMem, and buffers one fetched
// word in an IF/ID register drained by decode via valid/ready.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 1501
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        fault,
    output logic [31:0] fetch_count
);

    // Highest byte address at which a full word still fits in the memory.
    localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);

    typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic        out_valid_q;
    logic [31:0] out_instr_q;
    logic [31:0] out_pc_q;
    logic        fault_q;
    logic [31:0] fetch_count_q;

    logic        slot_free;
    logic        pc_over;
    logic        redirect_bad;
    logic [31:0] pc_d;
    logic [31:0] fetch_count_d;

    assign slot_free     = !out_valid_q || out_ready;
    assign pc_over       = pc_q > LAST_PC;
    assign redirect_bad  = (redirect_pc[1:0] != 2'b00) || (redirect_pc > LAST_PC);
    assign pc_d          = pc_q + 32'd4;
    assign fetch_count_d = fetch_count_q + 32'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            out_valid_q   <= 1'b0;
            out_instr_q   <= 32'h0;
            out_pc_q      <= 32'h0;
            fault_q       <= 1'b0;
            fetch_count_q <= 32'h0;
        end else begin
            case (state_q)
                IDLE: state_q <= FETCH;
                FETCH: begin
                    // Redirect wins over both stall and acceptance; the held word is dropped.
                    if (redirect_valid) begin
                        out_valid_q <= 1'b0;
                        if (redirect_bad) begin
                            fault_q <= 1'b1;
                            state_q <= HALT;
                        end else begin
                            pc_q <= redirect_pc;
                        end
                    end else if (slot_free && pc_over) begin
                        fault_q     <= 1'b1;
                        state_q     <= HALT;
                        out_valid_q <= 1'b0;
                    end else if (slot_free) begin
                        out_instr_q   <= imem_data;
                        out_pc_q      <= pc_q;
                        out_valid_q   <= 1'b1;
                        pc_q          <= pc_d;
                        fetch_count_q <= fetch_count_d;
                    end
                end
                HALT: out_valid_q <= 1'b0;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign imem_addr   = pc_q;
    assign out_valid   = out_valid_q;
    assign out_instr   = out_instr_q;
    assign out_pc      = out_pc_q;
    assign fault       = fault_q;
    assign fetch_count = fetch_count_q;

endmodule
